// File: rtl/misc_pkg.sv
// =============================================================================
// misc_pkg: shared constants and tree-sizing helpers for the misc gate library.
// Revision: 1.0
// =============================================================================
`default_nettype none

package misc_pkg;

    localparam int MAX_N_INS       = 64;
    localparam int MAX_PIPE_STAGES = 4;

    // Number of nodes at a given level of a halving tree; odd leftovers pass up.
    function automatic int tree_level_width(input int n, input int lvl);
        int w;
        w = n;
        for (int i = 0; i < lvl; i++) begin
            w = (w + 1) / 2;
        end
        return w;
    endfunction

    // Starting node index of a level when all levels are packed into one vector.
    function automatic int tree_level_offset(input int n, input int lvl);
        int off;
        off = 0;
        for (int i = 0; i < lvl; i++) begin
            off = off + tree_level_width(n, i);
        end
        return off;
    endfunction

endpackage : misc_pkg

`default_nettype wire

// File: rtl/xnor_reduce_xor_tree.sv
// =============================================================================
// xor_tree: balanced 2-input XOR reduction tree over N_INS bits.
// Revision: 1.0
// =============================================================================
`default_nettype none

module xor_tree
    import misc_pkg::*;
#(
    parameter int N_INS = 2
) (
    input  logic [N_INS-1:0] a_i,
    output logic             x_o
);

    localparam int LEVELS = $clog2(N_INS);
    localparam int TOTAL  = tree_level_offset(N_INS, LEVELS + 1);

    // All tree levels packed leaf-first; the last node is the root.
    logic [TOTAL-1:0] w_node;

    assign w_node[N_INS-1:0] = a_i;

    for (genvar l = 0; l < LEVELS; l++) begin : g_level
        localparam int W_IN    = tree_level_width(N_INS, l);
        localparam int W_OUT   = tree_level_width(N_INS, l + 1);
        localparam int OFF_IN  = tree_level_offset(N_INS, l);
        localparam int OFF_OUT = tree_level_offset(N_INS, l + 1);

        for (genvar i = 0; i < W_OUT; i++) begin : g_node
            if (2 * i + 1 < W_IN) begin : g_pair
                assign w_node[OFF_OUT+i] = w_node[OFF_IN+2*i] ^ w_node[OFF_IN+2*i+1];
            end else begin : g_pass
                assign w_node[OFF_OUT+i] = w_node[OFF_IN+2*i];
            end
        end
    end

    assign x_o = w_node[TOTAL-1];

endmodule : xor_tree

`default_nettype wire

// File: rtl/xnor_reduce.sv
// =============================================================================
// xnor_reduce: N-input reduction XNOR with combinational and pipelined outputs.
// Revision: 1.0
// =============================================================================
`default_nettype none

module xnor_reduce
    import misc_pkg::*;
#(
    parameter int N_INS       = 2,
    parameter int PIPE_STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_INS-1:0] a,
    input  logic             valid_in,
    output logic             y,
    output logic             y_q,
    output logic             valid_q
);

    if (N_INS < 1 || N_INS > MAX_N_INS) begin : g_bad_n_ins
        $error("xnor_reduce: N_INS out of range");
    end
    if (PIPE_STAGES < 1 || PIPE_STAGES > MAX_PIPE_STAGES) begin : g_bad_pipe
        $error("xnor_reduce: PIPE_STAGES out of range");
    end

    logic w_x;

    xor_tree #(
        .N_INS (N_INS)
    ) u_xor_tree (
        .a_i (a),
        .x_o (w_x)
    );

    assign y = ~w_x;

    logic [PIPE_STAGES-1:0] r_y_q;
    logic [PIPE_STAGES-1:0] r_v_q;
    logic [PIPE_STAGES-1:0] w_y_d;
    logic [PIPE_STAGES-1:0] w_v_d;

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        if (s == 0) begin : g_head
            assign w_y_d[s] = y;
            assign w_v_d[s] = valid_in;
        end else begin : g_tail
            assign w_y_d[s] = r_y_q[s-1];
            assign w_v_d[s] = r_v_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_q <= '0;
            r_v_q <= '0;
        end else begin
            r_y_q <= w_y_d;
            r_v_q <= w_v_d;
        end
    end

    assign y_q     = r_y_q[PIPE_STAGES-1];
    assign valid_q = r_v_q[PIPE_STAGES-1];

endmodule : xnor_reduce

`default_nettype wire

// File: tb/tb_xnor_reduce.sv
// =============================================================================
// tb_xnor_reduce: directed and random checks of xnor_reduce at several sizes.
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_xnor_reduce;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [63:0] a;

    always #5 clk = ~clk;

    logic y21, yq21, vq21;
    logic y23, yq23, vq23;
    logic y72, yq72, vq72;
    logic y34, yq34, vq34;
    logic y11, yq11, vq11;

    xnor_reduce #(.N_INS(2), .PIPE_STAGES(1)) u_n2p1 (
        .clk(clk), .rst(rst), .a(a[1:0]), .valid_in(valid_in),
        .y(y21), .y_q(yq21), .valid_q(vq21));
    xnor_reduce #(.N_INS(2), .PIPE_STAGES(3)) u_n2p3 (
        .clk(clk), .rst(rst), .a(a[1:0]), .valid_in(valid_in),
        .y(y23), .y_q(yq23), .valid_q(vq23));
    xnor_reduce #(.N_INS(7), .PIPE_STAGES(2)) u_n7p2 (
        .clk(clk), .rst(rst), .a(a[6:0]), .valid_in(valid_in),
        .y(y72), .y_q(yq72), .valid_q(vq72));
    xnor_reduce #(.N_INS(3), .PIPE_STAGES(4)) u_n3p4 (
        .clk(clk), .rst(rst), .a(a[2:0]), .valid_in(valid_in),
        .y(y34), .y_q(yq34), .valid_q(vq34));
    xnor_reduce #(.N_INS(1), .PIPE_STAGES(1)) u_n1p1 (
        .clk(clk), .rst(rst), .a(a[0:0]), .valid_in(valid_in),
        .y(y11), .y_q(yq11), .valid_q(vq11));

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    bit          h_rst [0:1023];
    logic [63:0] h_a   [0:1023];
    bit          h_v   [0:1023];

    // Input history, one entry per rising edge.
    always @(posedge clk) begin
        h_rst[edge_cnt] = rst;
        h_a[edge_cnt]   = a;
        h_v[edge_cnt]   = valid_in;
        edge_cnt++;
    end

    // Golden XNOR: true when the low n bits hold an even number of ones.
    function automatic logic golden(input logic [63:0] v, input int n);
        int ones;
        ones = 0;
        for (int i = 0; i < n; i++) ones += int'(v[i]);
        return (ones % 2 == 0);
    endfunction

    // {y_q, valid_q} after the most recent edge for a p-deep pipe.
    function automatic logic [1:0] exp_pipe(input int n, input int p);
        int k;
        k = edge_cnt - 1;
        for (int j = k - p + 1; j <= k; j++) begin
            if (h_rst[j]) return 2'b00;
        end
        return {golden(h_a[k-p+1], n), logic'(h_v[k-p+1])};
    endfunction

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (edge_cnt >= 5) begin
            chk("n2p1.y", {1'b0, y21}, {1'b0, golden(a, 2)});
            chk("n2p3.y", {1'b0, y23}, {1'b0, golden(a, 2)});
            chk("n7p2.y", {1'b0, y72}, {1'b0, golden(a, 7)});
            chk("n3p4.y", {1'b0, y34}, {1'b0, golden(a, 3)});
            chk("n1p1.y", {1'b0, y11}, {1'b0, golden(a, 1)});
            chk("n2p1.pipe", {yq21, vq21}, exp_pipe(2, 1));
            chk("n2p3.pipe", {yq23, vq23}, exp_pipe(2, 3));
            chk("n7p2.pipe", {yq72, vq72}, exp_pipe(7, 2));
            chk("n3p4.pipe", {yq34, vq34}, exp_pipe(3, 4));
            chk("n1p1.pipe", {yq11, vq11}, exp_pipe(1, 1));
        end
    end

    task automatic drive(input logic r, input logic [63:0] av, input logic v);
        @(posedge clk);
        #2;
        rst      = r;
        a        = av;
        valid_in = v;
    endtask

    initial begin
        rst      = 1'b1;
        a        = '0;
        valid_in = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset.n2p1", {yq21, vq21}, 2'b00);
        chk("reset.n2p3", {yq23, vq23}, 2'b00);
        chk("reset.n7p2", {yq72, vq72}, 2'b00);
        chk("reset.n3p4", {yq34, vq34}, 2'b00);

        // Combinational path while reset is held: y ignores clk/rst/valid_in.
        drive(1'b1, 64'b11, 1'b0); #1;
        chk("lit.n2.11", {1'b0, y21}, 2'b01);
        chk("lit.n3.011", {1'b0, y34}, 2'b01);
        chk("lit.n1.1", {1'b0, y11}, 2'b00);
        drive(1'b1, 64'b00, 1'b0); #1;
        chk("lit.n2.00", {1'b0, y21}, 2'b01);
        chk("lit.n3.000", {1'b0, y34}, 2'b01);
        chk("lit.n1.0", {1'b0, y11}, 2'b01);
        drive(1'b1, 64'b10, 1'b1); #1;
        chk("lit.n2.10", {1'b0, y21}, 2'b00);
        drive(1'b1, 64'b01, 1'b1); #1;
        chk("lit.n2.01", {1'b0, y21}, 2'b00);
        drive(1'b1, 64'b111, 1'b0); #1;
        chk("lit.n3.111", {1'b0, y34}, 2'b00);
        drive(1'b1, 64'h7F, 1'b0); #1;
        chk("lit.n7.ones", {1'b0, y72}, 2'b00);
        chk("lit.n2.ones", {1'b0, y21}, 2'b01);

        // Latency on the 3-deep pipe: 2'b10 then 2'b00.
        drive(1'b0, 64'b10, 1'b1);
        drive(1'b0, 64'b00, 1'b1);
        drive(1'b0, 64'b00, 1'b0);
        drive(1'b0, 64'b00, 1'b0);
        @(negedge clk);
        chk("lat.first", {yq23, vq23}, 2'b01);
        drive(1'b0, 64'b00, 1'b0);
        @(negedge clk);
        chk("lat.second", {yq23, vq23}, 2'b11);

        // Reset with two valid samples in flight.
        drive(1'b0, 64'b01, 1'b1);
        drive(1'b0, 64'b10, 1'b1);
        drive(1'b1, 64'b11, 1'b1);
        drive(1'b0, 64'b00, 1'b0);
        @(negedge clk);
        chk("flush.n2p3", {yq23, vq23}, 2'b00);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 64'($urandom()), 1'b0);
            @(negedge clk);
            chk("flush.novalid.n2p3", {1'b0, vq23}, 2'b00);
            chk("flush.novalid.n3p4", {1'b0, vq34}, 2'b00);
        end

        // Random traffic, checked every cycle by the compare process.
        for (int i = 0; i < 100; i++) begin
            drive(($urandom_range(0, 19) == 0), {32'($urandom()), 32'($urandom())},
                  1'($urandom_range(0, 1)));
        end
        repeat (6) drive(1'b0, 64'b0, 1'b0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_xnor_reduce

`default_nettype wire
